// File: rtl/flip_locator.sv
// flip_locator: locate the single bit that differs between i_a and i_b by a serial scan
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_a, i_b, i_valid   word pair in, accepted while o_ready (IDLE only)
//   o_idx, o_ERR        flipped-bit index (0 on error); error when diff count != 1
//   o_valid, i_ready    result handshake, outputs held under backpressure
module flip_locator #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [N-1:0] o_idx,
   output logic         o_ERR,
   output logic         o_valid,
   input  logic         i_ready
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state_q, state_d;
   logic [N-1:0] diff_q, diff_d, out_idx_q, out_idx_d;
   logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, idx_nx;
   logic [1:0] tally_q, tally_d, tally_nx;
   logic err_q, err_d, valid_q, valid_d, hit;
   always_comb begin
      state_d   = state_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      tally_d   = tally_q;
      idx_d     = idx_q;
      out_idx_d = out_idx_q;
      err_d     = err_q;
      valid_d   = valid_q;
      hit       = diff_q[cnt_q];
      // tally saturates at 2: "more than one" is all the error decision needs
      tally_nx  = (hit && tally_q != 2'd2) ? tally_q + 2'd1 : tally_q;
      idx_nx    = (hit && tally_q == 2'd0) ? cnt_q : idx_q;
      case (state_q)
         IDLE: if (i_valid) begin
            diff_d  = i_a ^ i_b;
            cnt_d   = '0;
            tally_d = '0;
            idx_d   = '0;
            state_d = SCAN;
         end
         SCAN: begin
            tally_d = tally_nx;
            idx_d   = idx_nx;
            // last bit folds straight into the registered result so o_valid rises N clocks after accept
            if (cnt_q == LAST) begin
               state_d   = DONE;
               valid_d   = 1'b1;
               err_d     = tally_nx != 2'd1;
               out_idx_d = (tally_nx == 2'd1) ? N'(idx_nx) : '0;
            end else
               cnt_d = cnt_q + 1'b1;
         end
         DONE: if (i_ready) begin
            valid_d   = 1'b0;
            out_idx_d = '0;
            err_d     = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         diff_q    <= '0;
         cnt_q     <= '0;
         tally_q   <= '0;
         idx_q     <= '0;
         out_idx_q <= '0;
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         tally_q   <= tally_d;
         idx_q     <= idx_d;
         out_idx_q <= out_idx_d;
         err_q     <= err_d;
         valid_q   <= valid_d;
      end
   end
   assign o_ready = state_q == IDLE;
   assign o_idx   = out_idx_q;
   assign o_ERR   = err_q;
   assign o_valid = valid_q;
endmodule

// File: tb/tb_flip_locator.sv
// tb_flip_locator: directed scoreboard bench for flip_locator (N=8)
module tb_flip_locator;
   localparam int N = 8;
   logic clk = 1'b0, rst, iv, ordy, ov, err, irdy;
   logic [N-1:0] a, b, idx;
   typedef struct {logic [N-1:0] idx; logic err; int acc;} exp_t;
   exp_t sb[$];
   int cyc = 0, errors = 0, checks = 0, last_acc = 0, prev_acc;
   logic vprev = 1'b0;
   logic [N-1:0] h_idx;
   logic h_err;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   flip_locator #(.N(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_valid(iv), .o_ready(ordy),
      .o_idx(idx), .o_ERR(err), .o_valid(ov), .i_ready(irdy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic exp_t model(input logic [N-1:0] xa, input logic [N-1:0] xb, input int acc);
      exp_t e;
      logic [N-1:0] d;
      d = xa ^ xb;
      e.err = $countones(d) != 1;
      e.idx = '0;
      e.acc = acc;
      if (!e.err)
         for (int i = 0; i < N; i++)
            if (d[i]) e.idx = N'(i);
      return e;
   endfunction
   task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb, input bit keep);
      int t = 0;
      while (!ordy && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (!ordy) chk("ready_timeout", 32'(ordy), 32'd1);
      a = xa;
      b = xb;
      iv = 1'b1;
      @(posedge clk); #1;
      sb.push_back(model(xa, xb, cyc));
      last_acc = cyc;
      chk("accepted", 32'(ordy), 32'd0);
      if (!keep) iv = 1'b0;
   endtask
   task automatic drain();
      int t = 0;
      while ((sb.size() != 0 || !ordy) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0 || !ordy) begin
         chk("drain", sb.size(), 0);
         sb.delete();
      end
   endtask
   always @(negedge clk) begin
      if (!rst && ov && !vprev) begin
         if (sb.size() == 0) chk("unexpected_valid", 32'(ov), 32'd0);
         else chk("latency", cyc - sb[0].acc, N);
      end
      if (!rst && ov && irdy) begin
         if (sb.size() == 0) chk("unexpected_result", 32'(ov), 32'd0);
         else begin
            chk("idx", idx, sb[0].idx);
            chk("err", 32'(err), 32'(sb[0].err));
            void'(sb.pop_front());
         end
      end
      vprev <= ov;
   end
   initial begin
      rst = 1'b1; iv = 1'b0; a = '0; b = '0; irdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ordy), 32'd1);
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_idx", idx, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      send(8'h5A, 8'h52, 0); drain();
      send(8'h00, 8'h80, 0); drain();
      send(8'hFF, 8'hFE, 0); drain();
      send(8'hA5, 8'hA5, 0); drain();
      send(8'h00, 8'h81, 0); drain();
      irdy = 1'b0;
      send(8'h3C, 8'h1C, 0);
      for (int t = 0; t < 20 && !ov; t++) begin
         @(posedge clk); #1;
      end
      chk("bp_valid_rise", 32'(ov), 32'd1);
      chk("bp_idx", idx, 32'd5);
      chk("bp_err", 32'(err), 32'd0);
      h_idx = idx;
      h_err = err;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 32'(ov), 32'd1);
         chk("bp_hold_idx", idx, h_idx);
         chk("bp_hold_err", 32'(err), 32'(h_err));
         chk("bp_hold_ready", 32'(ordy), 32'd0);
      end
      irdy = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", 32'(ov), 32'd0);
      chk("bp_ready_back", 32'(ordy), 32'd1);
      drain();
      send(8'hFF, 8'h00, 0);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_ready", 32'(ordy), 32'd1);
      chk("abort_valid", 32'(ov), 32'd0);
      chk("abort_idx", idx, 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      void'(sb.pop_back());
      @(negedge clk) rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(ov), 32'd0);
      send(8'h01, 8'h00, 0); drain();
      send(8'h10, 8'h00, 1);
      prev_acc = last_acc;
      send(8'h02, 8'h06, 1);
      chk("throughput1", last_acc - prev_acc, N + 2);
      prev_acc = last_acc;
      send(8'h40, 8'hC0, 0);
      chk("throughput2", last_acc - prev_acc, N + 2);
      drain();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
